// File: rtl/if_stage.sv
// ============================================================================
// if_stage -- instruction-fetch stage of the five-stage MIPS pipeline.
//
// Holds the PC, selects the next PC (PC+4, branch, immediate jump, register
// jump) from the ID-stage next-PC select, drives the instruction-memory
// address and owns the IF/ID pipeline register. There is no branch delay
// slot: a taken redirect squashes the instruction fetched in the same cycle.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   ID_NPCOp         next-PC select from ID (00 +4, 01 branch, 10 j, 11 jr)
//   ID_Imm16         branch offset field of the ID instruction
//   ID_Index26       jump index field of the ID instruction
//   ID_RegRs         forwarded GPR[rs] for jr/jalr
//   Stall            hazard stall; freezes PC, IF/ID and the counter
//   IMem_Addr        fetch address (pure register output, equals PC)
//   IMem_RData       fetched instruction
//   IMem_Ready       IMem_RData is valid this cycle
//   ID_Instr         IF/ID instruction (0 = sll $0,$0,0 when bubbled)
//   ID_PC            IF/ID PC
//   ID_PCPlus4       IF/ID PC+4
//   ID_Valid         IF/ID holds a real instruction
//   RedirectCount    number of accepted non-PLUS4 redirects (wrapping)
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ID_NPCOp,
    input  logic [15:0]      ID_Imm16,
    input  logic [25:0]      ID_Index26,
    input  logic [31:0]      ID_RegRs,
    input  logic             Stall,
    output logic [31:0]      IMem_Addr,
    input  logic [31:0]      IMem_RData,
    input  logic             IMem_Ready,
    output logic [31:0]      ID_Instr,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_PCPlus4,
    output logic             ID_Valid,
    output logic [CNT_W-1:0] RedirectCount
);

    typedef enum logic [1:0] {
        NPC_PLUS4    = 2'b00,
        NPC_BRANCH   = 2'b01,
        NPC_JUMP_IMM = 2'b10,
        NPC_JUMP_REG = 2'b11
    } npc_op_e;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] target;
    logic        redirect;

    // The fetch address comes straight from the PC flop, so no input can
    // reach IMem_Addr combinationally.
    assign IMem_Addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{ID_Imm16[15]}}, ID_Imm16, 2'b00};

    // A bubble in ID never redirects, which is what rules out back-to-back
    // redirects.
    assign redirect  = ID_Valid && (npc_op_e'(ID_NPCOp) != NPC_PLUS4);

    // Targets are relative to the instruction sitting in ID, not to the PC.
    always_comb begin
        // NOTE: assign a default before the case so every path drives target;
        // a missing path would otherwise infer a latch.
        target = pc_plus4;
        case (npc_op_e'(ID_NPCOp))
            NPC_BRANCH:   target = ID_PCPlus4 + br_offset;
            NPC_JUMP_IMM: target = {ID_PCPlus4[31:28], ID_Index26, 2'b00};
            NPC_JUMP_REG: target = ID_RegRs;
            default:      target = pc_plus4;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            ID_Instr      <= 32'd0;
            ID_PC         <= 32'd0;
            ID_PCPlus4    <= 32'd0;
            ID_Valid      <= 1'b0;
            RedirectCount <= '0;
        end else if (!Stall) begin
            if (redirect) begin
                // The in-flight fetch is discarded whether or not it is ready;
                // ID_PC/ID_PCPlus4 hold under the bubble.
                pc            <= target;
                ID_Instr      <= 32'd0;
                ID_Valid      <= 1'b0;
                RedirectCount <= RedirectCount + CNT_W'(1);
            end else if (IMem_Ready) begin
                pc         <= pc_plus4;
                ID_Instr   <= IMem_RData;
                ID_PC      <= pc;
                ID_PCPlus4 <= pc_plus4;
                ID_Valid   <= 1'b1;
            end else begin
                // Memory wait: retry the same address, feed ID a NOP.
                ID_Instr <= 32'd0;
                ID_Valid <= 1'b0;
            end
        end
        // Stall: redirect is not evaluated because ID operands may be stale.
    end

endmodule

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage -- self-checking bench for if_stage.
//
// Directed steps walk through reset, sequential fetch, memory wait, branch,
// immediate and register jumps, a stall over a pending redirect and an
// asynchronous mid-cycle reset; a randomized phase follows. A reference model
// of the fetch stage, written as plain arithmetic over the stage's rules,
// supplies every expected value.
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  ID_NPCOp;
    logic [15:0] ID_Imm16;
    logic [25:0] ID_Index26;
    logic [31:0] ID_RegRs;
    logic        Stall;
    logic [31:0] IMem_Addr;
    logic [31:0] IMem_RData;
    logic        IMem_Ready;
    logic [31:0] ID_Instr;
    logic [31:0] ID_PC;
    logic [31:0] ID_PCPlus4;
    logic        ID_Valid;
    logic [31:0] RedirectCount;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ID_NPCOp      (ID_NPCOp),
        .ID_Imm16      (ID_Imm16),
        .ID_Index26    (ID_Index26),
        .ID_RegRs      (ID_RegRs),
        .Stall         (Stall),
        .IMem_Addr     (IMem_Addr),
        .IMem_RData    (IMem_RData),
        .IMem_Ready    (IMem_Ready),
        .ID_Instr      (ID_Instr),
        .ID_PC         (ID_PC),
        .ID_PCPlus4    (ID_PCPlus4),
        .ID_Valid      (ID_Valid),
        .RedirectCount (RedirectCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic        m_valid;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.addr", tag),  IMem_Addr,          m_pc);
        check($sformatf("%s.instr", tag), ID_Instr,           m_instr);
        check($sformatf("%s.idpc", tag),  ID_PC,              m_idpc);
        check($sformatf("%s.idpc4", tag), ID_PCPlus4,         m_idpc4);
        check($sformatf("%s.valid", tag), {31'd0, ID_Valid},  {31'd0, m_valid});
        check($sformatf("%s.cnt", tag),   RedirectCount,      m_cnt);
    endtask

    task automatic reset_model();
        m_pc    = 32'h0000_3000;
        m_instr = 32'd0;
        m_idpc  = 32'd0;
        m_idpc4 = 32'd0;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
    endtask

    function automatic logic [31:0] model_target(input logic [1:0] op, input logic [15:0] imm,
                                                 input logic [25:0] idx, input logic [31:0] rs);
        int signed off;
        logic [31:0] t;
        off = $signed(imm);
        case (op)
            2'd1:    t = m_idpc4 + 32'(off * 4);
            2'd2:    t = (m_idpc4 & 32'hF000_0000) | (32'(idx) * 4);
            2'd3:    t = rs;
            default: t = m_pc + 32'd4;
        endcase
        return t;
    endfunction

    // Drive one cycle's inputs, advance the model across the edge, then
    // compare every output 1 time unit after the edge.
    task automatic step(input string tag, input logic [1:0] op, input logic [15:0] imm,
                        input logic [25:0] idx, input logic [31:0] rs,
                        input logic stl, input logic rdy);
        logic [31:0] rdata;
        logic [31:0] n_pc, n_instr, n_idpc, n_idpc4, n_cnt;
        logic        n_valid;
        rdata      = $urandom;
        ID_NPCOp   = op;
        ID_Imm16   = imm;
        ID_Index26 = idx;
        ID_RegRs   = rs;
        Stall      = stl;
        IMem_Ready = rdy;
        IMem_RData = rdata;
        n_pc = m_pc; n_instr = m_instr; n_idpc = m_idpc; n_idpc4 = m_idpc4;
        n_valid = m_valid; n_cnt = m_cnt;
        if (stl) begin
            // everything holds
        end else if (m_valid && op != 2'd0) begin
            n_pc    = model_target(op, imm, idx, rs);
            n_instr = 32'd0;
            n_valid = 1'b0;
            n_cnt   = m_cnt + 32'd1;
        end else if (rdy) begin
            n_instr = rdata;
            n_idpc  = m_pc;
            n_idpc4 = m_pc + 32'd4;
            n_valid = 1'b1;
            n_pc    = m_pc + 32'd4;
        end else begin
            n_instr = 32'd0;
            n_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_idpc = n_idpc; m_idpc4 = n_idpc4;
        m_valid = n_valid; m_cnt = n_cnt;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset ----
        rst = 1'b1;
        ID_NPCOp = 2'd0; ID_Imm16 = 16'd0; ID_Index26 = 26'd0; ID_RegRs = 32'd0;
        Stall = 1'b0; IMem_Ready = 1'b1; IMem_RData = 32'd0;
        reset_model();
        #12;
        check_all("reset");
        check("reset_addr", IMem_Addr, 32'h0000_3000);
        rst = 1'b0;

        // ---- sequential fetch, then two memory wait cycles at 0x3008 ----
        step("seq0", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("seq0_addr", IMem_Addr, 32'h3004);
        check("seq0_idpc", ID_PC, 32'h3000);
        check("seq0_valid", {31'd0, ID_Valid}, 32'd1);
        step("seq1", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("seq1_addr", IMem_Addr, 32'h3008);
        step("wait0", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0);
        check("wait0_addr", IMem_Addr, 32'h3008);
        check("wait0_valid", {31'd0, ID_Valid}, 32'd0);
        step("wait1", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0);
        check("wait1_addr", IMem_Addr, 32'h3008);
        step("wait_end", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("wait_end_idpc", ID_PC, 32'h3008);
        check("wait_end_addr", IMem_Addr, 32'h300C);

        // ---- branch from ID_PC=0x3010 with offset -4 words ----
        step("seq2", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        step("seq3", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("br_idpc", ID_PC, 32'h3010);
        step("branch", 2'd1, 16'hFFFC, 26'd0, 32'd0, 1'b0, 1'b1);
        check("br_addr", IMem_Addr, 32'h3004);
        check("br_bubble", {31'd0, ID_Valid}, 32'd0);
        check("br_cnt", RedirectCount, 32'd1);
        step("br_after", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("br_after_idpc", ID_PC, 32'h3004);

        // ---- immediate jump from ID_PC=0x3020 ----
        for (int i = 0; i < 20 && m_idpc != 32'h3020; i++)
            step("to3020", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("j_idpc", ID_PC, 32'h3020);
        step("jump_imm", 2'd2, 16'd0, 26'h0000C10, 32'd0, 1'b0, 1'b1);
        check("j_addr", IMem_Addr, 32'h0000_3040);
        check("j_cnt", RedirectCount, 32'd2);
        step("j_after", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);

        // ---- register jump ----
        step("jump_reg", 2'd3, 16'd0, 26'd0, 32'h0040_0000, 1'b0, 1'b1);
        check("jr_addr", IMem_Addr, 32'h0040_0000);
        check("jr_cnt", RedirectCount, 32'd3);
        step("jr_after", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);

        // ---- stall over a pending branch, then release ----
        for (int i = 0; i < 3; i++) begin
            step("stall", 2'd1, 16'h0008, 26'd0, 32'd0, 1'b1, 1'b1);
            check("stall_addr", IMem_Addr, 32'h0040_0004);
            check("stall_cnt", RedirectCount, 32'd3);
        end
        step("stall_rel", 2'd1, 16'h0008, 26'd0, 32'd0, 1'b0, 1'b1);
        check("rel_addr", IMem_Addr, 32'h0040_0024);
        check("rel_cnt", RedirectCount, 32'd4);
        step("rel_once", 2'd1, 16'h0008, 26'd0, 32'd0, 1'b0, 1'b1);
        check("rel_once_cnt", RedirectCount, 32'd4);

        // ---- randomized phase ----
        for (int i = 0; i < 300; i++) begin
            step("rand", 2'($urandom_range(0, 3)), 16'($urandom), 26'($urandom), $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        // ---- asynchronous reset mid-cycle at PC=0x3050, during a stall ----
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 30 && m_pc != 32'h3050; i++)
            step("to3050", 2'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
        check("pre_rst_addr", IMem_Addr, 32'h3050);
        #2;
        ID_NPCOp = 2'd1;
        Stall = 1'b1;
        rst = 1'b1;
        reset_model();
        #1;
        check_all("async_rst");
        check("async_rst_addr", IMem_Addr, 32'h3000);
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;
        step("restart", 2'd1, 16'h0008, 26'd0, 32'd0, 1'b0, 1'b1);
        check("restart_idpc", ID_PC, 32'h3000);
        check("restart_addr", IMem_Addr, 32'h3004);
        check("restart_cnt", RedirectCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
